// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the register-file write port
// and the hazard logic; the slave modport is the arbiter's view.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned REG_W = 5;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              md_valid;
  logic [REG_W-1:0]  md_reg;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  logic              ctrl_writeEnable;
  logic [REG_W-1:0]  ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;

  logic [REG_W-1:0]  chk_reg;
  logic              chk_pending;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, chk_reg,
    input  alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           chk_pending, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, chk_reg,
    output alu_ready, md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           chk_pending, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and mul/div writeback sources onto one register-file write port.
// Define WB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed A priority.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clock,
  input logic                ctrl_reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  logic              aFull;
  logic              mFull;
  wbEntry_t          aBuf;
  wbEntry_t          mBuf;
  logic              mOlder;
  logic              writeEnable;
  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  conflictCnt;

  logic              bothFull;
  logic              sameDest;
  logic              policyA;
  logic              grantA;
  logic              grantM;
  logic              aReady;
  logic              mReady;
  logic              aLoad;
  logic              mLoad;
  logic              aFullNext;
  logic              mFullNext;
  logic              mOlderNext;
  logic              chkPending;

`ifdef WB_ROUND_ROBIN_EN
  logic              rrPtr;  // 0: A wins the next different-destination conflict
`endif

  // Grant selection, handshake and next-state of the holding buffers
  always_comb begin
    bothFull   = aFull && mFull;
    sameDest   = (aBuf.dest == mBuf.dest);
`ifdef WB_ROUND_ROBIN_EN
    policyA    = !rrPtr;
`else
    policyA    = 1'b1;
`endif
    grantA     = 1'b0;
    grantM     = 1'b0;
    if (bothFull) begin
      if (sameDest) begin
        grantA = !mOlder;
        grantM = mOlder;
      end else begin
        grantA = policyA;
        grantM = !policyA;
      end
    end else begin
      grantA = aFull;
      grantM = mFull;
    end

    aReady     = !aFull || grantA;
    mReady     = !mFull || grantM;
    // Register 0 writes complete the handshake but are dropped here
    aLoad      = bus.alu_valid && aReady && (bus.alu_reg != '0);
    mLoad      = bus.md_valid && mReady && (bus.md_reg != '0);
    aFullNext  = aLoad || (aFull && !grantA);
    mFullNext  = mLoad || (mFull && !grantM);

    // A newly loaded A is always the younger entry, including a same-edge load
    mOlderNext = mOlder;
    if (aLoad) begin
      mOlderNext = 1'b1;
    end else if (mLoad) begin
      mOlderNext = 1'b0;
    end
  end

  assign chkPending = (bus.chk_reg != '0) &&
                      ((aFull && (aBuf.dest == bus.chk_reg)) ||
                       (mFull && (mBuf.dest == bus.chk_reg)) ||
                       (writeEnable && (writeReg == bus.chk_reg)));

  // Buffers, write-port registers and contention counter
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      aFull       <= 1'b0;
      mFull       <= 1'b0;
      aBuf        <= '0;
      mBuf        <= '0;
      mOlder      <= 1'b0;
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
      conflictCnt <= '0;
`ifdef WB_ROUND_ROBIN_EN
      rrPtr       <= 1'b0;
`endif
    end else begin
      aFull  <= aFullNext;
      mFull  <= mFullNext;
      mOlder <= mOlderNext;
      if (aLoad) begin
        aBuf <= '{dest: bus.alu_reg, data: bus.alu_data};
      end
      if (mLoad) begin
        mBuf <= '{dest: bus.md_reg, data: bus.md_data};
      end

      writeEnable <= grantA || grantM;
      if (grantA) begin
        writeReg  <= aBuf.dest;
        writeData <= aBuf.data;
      end else if (grantM) begin
        writeReg  <= mBuf.dest;
        writeData <= mBuf.data;
      end

      if (bothFull && (conflictCnt != {CNT_W{1'b1}})) begin
        conflictCnt <= conflictCnt + CNT_W'(1);
      end
`ifdef WB_ROUND_ROBIN_EN
      // Hand priority to whichever source lost this conflict
      if (bothFull) begin
        rrPtr <= grantA;
      end
`endif
    end
  end

  assign bus.alu_ready        = aReady;
  assign bus.md_ready         = mReady;
  assign bus.ctrl_writeEnable = writeEnable;
  assign bus.ctrl_writeReg    = writeReg;
  assign bus.data_writeReg    = writeData;
  assign bus.chk_pending      = chkPending;
  assign bus.conflict_cnt     = conflictCnt;

endmodule
